muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_unit_div_step.sv | 20 ++
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// controller states and small operation-decode helpers.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor, keep the difference only if it did not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;

  // The shifted remainder needs one extra bit because it may exceed the divisor width.
  assign shifted = {rem_i, bit_i};
  assign q_o     = (shifted >= {1'b0, divisor_i});
  assign rem_o   = q_o ? WIDTH'(shifted - {1'b0, divisor_i}) : shifted[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit: operands are reduced to magnitudes,
// processed one bit per cycle, then sign-corrected by a shared fix-up stage.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, step, finish;

  logic             div_q, neg_res_q, neg_rem_q, div_zero_q;
  logic [WIDTH-1:0] opb_q, acc_hi_q, acc_lo_q, acc_hi_d, acc_lo_d;
  logic [WIDTH-1:0] hi_q, lo_q;

  // ---------------- controller ----------------
  // NOTE: the reset is in the sensitivity list so it acts without a clock, and
  // state flops use <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Cancel overrides everything, including a start that arrives in IDLE.
  always_comb begin
    state_d = state_q;
    if (cancel_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_i) state_d = CALC;
        CALC:    if (cnt_q == '0) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    busy_o  = 1'b0;
    ready_o = 1'b0;
    accept  = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: accept = start_i & ~cancel_i;
      CALC: begin
        busy_o = 1'b1;
        step   = (cnt_q != '0);
        finish = (cnt_q == '0) & ~cancel_i;
      end
      DONE: begin
        busy_o  = 1'b1;
        ready_o = ~cancel_i;
      end
      default: ;
    endcase
  end

  assign stall_o = (start_i | busy_o) & ~ready_o;

  // ---------------- operand decode ----------------
  op_e              op_in;
  logic             in_signed, in_div, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign op_in     = op_e'(op_i);
  assign in_signed = op_is_signed(op_in);
  assign in_div    = op_is_div(op_in);
  assign a_neg     = in_signed & a_i[WIDTH-1];
  assign b_neg     = in_signed & b_i[WIDTH-1];
  assign a_mag     = a_neg ? (~a_i + WIDTH'(1)) : a_i;
  assign b_mag     = b_neg ? (~b_i + WIDTH'(1)) : b_i;

  // ---------------- iteration datapath ----------------
  // Multiply keeps {partial product, multiplier} in {acc_hi, acc_lo}; divide
  // keeps {partial remainder, dividend/quotient} in the same pair.
  logic [WIDTH:0]   mul_sum, mul_add;
  logic [WIDTH-1:0] rem_nx;
  logic             q_bit;

  assign mul_sum = {1'b0, acc_hi_q} + {1'b0, opb_q};
  assign mul_add = acc_lo_q[0] ? mul_sum : {1'b0, acc_hi_q};

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (acc_hi_q),
    .bit_i     (acc_lo_q[WIDTH-1]),
    .divisor_i (opb_q),
    .rem_o     (rem_nx),
    .q_o       (q_bit)
  );

  always_comb begin
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    if (accept) begin
      acc_hi_d = '0;
      acc_lo_d = in_div ? a_mag : b_mag;
      cnt_d    = CNT_W'(WIDTH);
    end else if (step) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (div_q) begin
        acc_hi_d = rem_nx;
        acc_lo_d = {acc_lo_q[WIDTH-2:0], q_bit};
      end else begin
        acc_hi_d = mul_add[WIDTH:1];
        acc_lo_d = {mul_add[0], acc_lo_q[WIDTH-1:1]};
      end
    end
  end

  // ---------------- shared sign fix-up ----------------
  // Multiply negates the 2*WIDTH pair (borrow ripples into hi only when lo is 0);
  // divide negates quotient and remainder independently.
  logic             neg_lo, neg_hi, hi_cin;
  logic [WIDTH-1:0] lo_fix, hi_fix;

  assign neg_lo = div_q ? (neg_res_q & ~div_zero_q) : neg_res_q;
  assign neg_hi = div_q ? neg_rem_q : neg_res_q;
  assign hi_cin = div_q | (acc_lo_q == '0);
  assign lo_fix = neg_lo ? (~acc_lo_q + WIDTH'(1)) : acc_lo_q;
  assign hi_fix = neg_hi ? (~acc_hi_q + WIDTH'(hi_cin)) : acc_hi_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opb_q      <= '0;
      div_q      <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      if (accept) begin
        opb_q      <= in_div ? b_mag : a_mag;
        div_q      <= in_div;
        neg_res_q  <= a_neg ^ b_neg;
        neg_rem_q  <= a_neg;
        div_zero_q <= in_div & (b_i == '0);
      end
      if (finish) begin
        hi_q <= hi_fix;
        lo_q <= lo_fix;
      end
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule
